multi_debouncer: RTL and testbench

- Parametrised N-channel debouncer for mechanical switches and buttons.
- Each channel runs its own synchroniser, a two-state stability FSM and a counter.
- Outputs per channel: a debounced level plus one-cycle rise/fall event pulses.
- Sits between the board I/O pins and the control logic; supersedes the single-channel debouncer.

---
 rtl/multi_debouncer_pkg.sv | 14 +
 rtl/multi_debouncer_if.sv | 28 ++
 rtl/multi_debouncer_debounce_channel.sv | 134 +++++++++++++
 rtl/multi_debouncer.sv | 42 ++++
 tb/tb_multi_debouncer.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_debouncer_pkg.sv
// rtl/multi_debouncer_pkg.sv - shared types and width helper for the multi-channel debouncer
package multi_debouncer_pkg;

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } deb_state_t;

    // Width needed to hold values 0..n-1, never narrower than one bit
    function automatic int safe_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multi_debouncer_if.sv
// rtl/multi_debouncer_if.sv - raw inputs and debounced outputs bundle for multi_debouncer
interface multi_debouncer_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] din;
    logic [CHANNELS-1:0] dout;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] hold;

    // Board / control side: drives the raw pins, consumes debounced results
    modport master (
        output din,
        input  dout,
        input  rise,
        input  fall,
        input  hold
    );

    // Debouncer side
    modport slave (
        input  din,
        output dout,
        output rise,
        output fall,
        output hold
    );
endinterface

// File: rtl/multi_debouncer_debounce_channel.sv
// rtl/multi_debouncer_debounce_channel.sv - one channel: synchroniser, stability FSM, counter; hold detect under MULTI_DEBOUNCER_HOLD_DETECT_EN
module multi_debouncer_debounce_channel
    import multi_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int SYNC_STAGES     = 2,
    parameter int HOLD_CYCLES     = 1000000
) (
    input  logic clk,
    input  logic as_reset_n,
    input  logic i_din,
    output logic o_dout,
    output logic o_rise,
    output logic o_fall,
    output logic o_hold
);

    localparam int CNT_W = safe_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    deb_state_t             r_state;
    deb_state_t             w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   r_dout;
    logic                   w_dout_nxt;
    logic                   r_rise;
    logic                   w_rise_nxt;
    logic                   r_fall;
    logic                   w_fall_nxt;

    assign w_s = r_sync[SYNC_STAGES-1];

    // Shift the raw pin through the synchroniser chain
    always_ff @(posedge clk or negedge as_reset_n) begin
        if (!as_reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
        end
    end

    // FSM, counter, level and pulse registers
    always_ff @(posedge clk or negedge as_reset_n) begin
        if (!as_reset_n) begin
            r_state <= STABLE;
            r_cnt   <= '0;
            r_dout  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dout  <= w_dout_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // Next state: dout follows s only after DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dout_nxt  = r_dout;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            STABLE: begin
                if (w_s != r_dout) begin
                    w_state_nxt = PENDING;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            PENDING: begin
                if (w_s == r_dout) begin
                    w_state_nxt = STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_dout_nxt  = w_s;
                    w_rise_nxt  = w_s;
                    w_fall_nxt  = ~w_s;
                    w_state_nxt = STABLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = STABLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_dout = r_dout;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

`ifdef MULTI_DEBOUNCER_HOLD_DETECT_EN
    localparam int HOLD_W = safe_width(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_hold;

    // Long-press counter: saturates at HOLD_CYCLES so the pulse fires once per press
    always_ff @(posedge clk or negedge as_reset_n) begin
        if (!as_reset_n) begin
            r_hold_cnt <= '0;
            r_hold     <= 1'b0;
        end else if (r_dout) begin
            if (r_hold_cnt != HOLD_MAX) begin
                r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end
            r_hold <= (r_hold_cnt == HOLD_LAST);
        end else begin
            r_hold_cnt <= '0;
            r_hold     <= 1'b0;
        end
    end

    assign o_hold = r_hold;
`else
    wire w_unused_hold_cycles = (HOLD_CYCLES > 0);
    assign o_hold = 1'b0;
`endif

endmodule

// File: rtl/multi_debouncer.sv
// rtl/multi_debouncer.sv - N-channel switch debouncer top; optional long-press detect via MULTI_DEBOUNCER_HOLD_DETECT_EN
module multi_debouncer
    import multi_debouncer_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int SYNC_STAGES     = 2,
    parameter int HOLD_CYCLES     = 1000000
) (
    input  logic              clk,
    input  logic              as_reset_n,
    multi_debouncer_if.slave  bus
);

    logic [CHANNELS-1:0] w_dout;
    logic [CHANNELS-1:0] w_rise;
    logic [CHANNELS-1:0] w_fall;
    logic [CHANNELS-1:0] w_hold;

    // Channels share nothing but clock and reset
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        multi_debouncer_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES),
            .HOLD_CYCLES     (HOLD_CYCLES)
        ) u_ch (
            .clk        (clk),
            .as_reset_n (as_reset_n),
            .i_din      (bus.din[g]),
            .o_dout     (w_dout[g]),
            .o_rise     (w_rise[g]),
            .o_fall     (w_fall[g]),
            .o_hold     (w_hold[g])
        );
    end

    assign bus.dout = w_dout;
    assign bus.rise = w_rise;
    assign bus.fall = w_fall;
    assign bus.hold = w_hold;

endmodule

// File: tb/tb_multi_debouncer.sv
// tb/tb_multi_debouncer.sv - directed self-checking bench for multi_debouncer
module tb_multi_debouncer;

`ifdef MULTI_DEBOUNCER_HOLD_DETECT_EN
    localparam int HOLD_EXP_PULSES = 1;
    localparam int HOLD_EXP_STEP   = 20;
`else
    localparam int HOLD_EXP_PULSES = 0;
    localparam int HOLD_EXP_STEP   = 0;
`endif

    logic clk;
    logic as_reset_n;
    int   n_cmp;
    int   n_bad;

    multi_debouncer_if #(.CHANNELS(4)) bus ();

    multi_debouncer #(
        .CHANNELS        (4),
        .DEBOUNCE_CYCLES (8),
        .SYNC_STAGES     (2),
        .HOLD_CYCLES     (20)
    ) dut (
        .clk        (clk),
        .as_reset_n (as_reset_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        as_reset_n = 1'b0;
        bus.din    = 4'hF;
        repeat (3) step();
        n_cmp++;
        if ({bus.dout, bus.rise, bus.fall, bus.hold} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_hold: got %h required 0000", {bus.dout, bus.rise, bus.fall, bus.hold});
        end
        #2 as_reset_n = 1'b1;
        repeat (9) step();
        n_cmp++;
        if (bus.dout !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_edge9_dout: got %h required 0", bus.dout);
        end
        step();
        n_cmp++;
        if (bus.dout !== 4'hF || bus.rise !== 4'hF || bus.fall !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_edge10: dout %h rise %h fall %h required F F 0", bus.dout, bus.rise, bus.fall);
        end
        step();
        n_cmp++;
        if (bus.dout !== 4'hF || bus.rise !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_edge11: dout %h rise %h required F 0", bus.dout, bus.rise);
        end
        #2 as_reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.dout, bus.rise, bus.fall, bus.hold} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_async: got %h required 0000", {bus.dout, bus.rise, bus.fall, bus.hold});
        end
        bus.din = 4'h0;
        step();
        #2 as_reset_n = 1'b1;
        step();
    endtask

    task automatic test_clean_step();
        int fall_seen;
        int fall_cnt;
        fall_seen  = 0;
        fall_cnt   = 0;
        bus.din[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (bus.fall !== 4'h0) fall_seen++;
            n_cmp++;
            if (bus.dout[0] !== (k == 10) || bus.rise[0] !== (k == 10)) begin
                n_bad++;
                $display("FAIL clean_step_edge%0d: dout0 %b rise0 %b required %b", k, bus.dout[0], bus.rise[0], (k == 10));
            end
        end
        step();
        if (bus.fall !== 4'h0) fall_seen++;
        n_cmp++;
        if (bus.rise[0] !== 1'b0 || bus.dout[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL clean_step_pulse_width: rise0 %b dout0 %b required 0 1", bus.rise[0], bus.dout[0]);
        end
        n_cmp++;
        if (fall_seen !== 0) begin
            n_bad++;
            $display("FAIL clean_step_no_fall: got %0d fall cycles required 0", fall_seen);
        end
        bus.din[0] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (bus.fall[0] === 1'b1) fall_cnt++;
        end
        n_cmp++;
        if (fall_cnt !== 1 || bus.dout[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL clean_step_fall: pulses %0d dout0 %b required 1 0", fall_cnt, bus.dout[0]);
        end
    endtask

    task automatic test_bounce();
        int pulses;
        int high_seen;
        pulses    = 0;
        high_seen = 0;
        for (int k = 0; k < 40; k++) begin
            bus.din[1] = ((k % 5) < 3);
            step();
            if (bus.rise[1] === 1'b1 || bus.fall[1] === 1'b1) pulses++;
            if (bus.dout[1] !== 1'b0) high_seen++;
        end
        bus.din[1] = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (bus.rise[1] === 1'b1 || bus.fall[1] === 1'b1) pulses++;
            if (bus.dout[1] !== 1'b0) high_seen++;
        end
        n_cmp++;
        if (high_seen !== 0) begin
            n_bad++;
            $display("FAIL bounce_dout: got %0d high cycles required 0", high_seen);
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++;
            $display("FAIL bounce_pulses: got %0d required 0", pulses);
        end
    endtask

    task automatic test_threshold();
        int high_seen;
        high_seen  = 0;
        bus.din[2] = 1'b1;
        repeat (7) step();
        bus.din[2] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (bus.dout[2] !== 1'b0 || bus.rise[2] !== 1'b0) high_seen++;
        end
        n_cmp++;
        if (high_seen !== 0) begin
            n_bad++;
            $display("FAIL threshold_7: got %0d changed cycles required 0", high_seen);
        end
        bus.din[2] = 1'b1;
        repeat (8) step();
        bus.din[2] = 1'b0;
        step();
        n_cmp++;
        if (bus.dout[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL threshold_8_edge9: dout2 %b required 0", bus.dout[2]);
        end
        step();
        n_cmp++;
        if (bus.dout[2] !== 1'b1 || bus.rise[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL threshold_8_rise: dout2 %b rise2 %b required 1 1", bus.dout[2], bus.rise[2]);
        end
        repeat (7) step();
        n_cmp++;
        if (bus.dout[2] !== 1'b1 || bus.fall[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL threshold_low7: dout2 %b fall2 %b required 1 0", bus.dout[2], bus.fall[2]);
        end
        step();
        n_cmp++;
        if (bus.dout[2] !== 1'b0 || bus.fall[2] !== 1'b1 || bus.rise[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL threshold_low8: dout2 %b fall2 %b rise2 %b required 0 1 0", bus.dout[2], bus.fall[2], bus.rise[2]);
        end
        repeat (3) step();
    endtask

    task automatic test_independence();
        bus.din = 4'b1010;
        repeat (9) step();
        n_cmp++;
        if (bus.dout !== 4'b0000 || bus.rise !== 4'b0000) begin
            n_bad++;
            $display("FAIL indep_edge9: dout %b rise %b required 0000 0000", bus.dout, bus.rise);
        end
        step();
        n_cmp++;
        if (bus.dout !== 4'b1010 || bus.rise !== 4'b1010 || bus.fall !== 4'b0000) begin
            n_bad++;
            $display("FAIL indep_edge10: dout %b rise %b fall %b required 1010 1010 0000", bus.dout, bus.rise, bus.fall);
        end
        step();
        n_cmp++;
        if (bus.dout !== 4'b1010 || bus.rise !== 4'b0000) begin
            n_bad++;
            $display("FAIL indep_edge11: dout %b rise %b required 1010 0000", bus.dout, bus.rise);
        end
        bus.din = 4'b0000;
        repeat (9) step();
        step();
        n_cmp++;
        if (bus.dout !== 4'b0000 || bus.fall !== 4'b1010) begin
            n_bad++;
            $display("FAIL indep_fall: dout %b fall %b required 0000 1010", bus.dout, bus.fall);
        end
        repeat (2) step();
    endtask

    task automatic test_reset_mid_pending();
        bus.din = 4'b0001;
        repeat (7) step();
        #2 as_reset_n = 1'b0;
        step();
        #2 as_reset_n = 1'b1;
        repeat (9) step();
        n_cmp++;
        if (bus.dout[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL midpend_edge9: dout0 %b required 0", bus.dout[0]);
        end
        step();
        n_cmp++;
        if (bus.dout[0] !== 1'b1 || bus.rise[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL midpend_edge10: dout0 %b rise0 %b required 1 1", bus.dout[0], bus.rise[0]);
        end
    endtask

    task automatic test_hold();
        int pulses;
        int other;
        int at_step;
        pulses  = 0;
        other   = 0;
        at_step = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (bus.hold[0] === 1'b1) begin
                pulses++;
                at_step = k;
            end
            if (bus.hold[3:1] !== 3'b000) other++;
        end
        n_cmp++;
        if (pulses !== HOLD_EXP_PULSES) begin
            n_bad++;
            $display("FAIL hold_count: got %0d required %0d", pulses, HOLD_EXP_PULSES);
        end
        n_cmp++;
        if (at_step !== HOLD_EXP_STEP) begin
            n_bad++;
            $display("FAIL hold_timing: got step %0d required %0d", at_step, HOLD_EXP_STEP);
        end
        n_cmp++;
        if (other !== 0) begin
            n_bad++;
            $display("FAIL hold_other_channels: got %0d required 0", other);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        as_reset_n = 1'b0;
        bus.din    = 4'h0;
        test_reset();
        test_clean_step();
        test_bounce();
        test_threshold();
        test_independence();
        test_reset_mid_pending();
        test_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
